fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core.
- Owns the PC and drives the instruction-memory request handshake.
- Consumes the hazard unit's `hold` (stall) and branch/jump redirect outputs, and the ID-stage branch target.
- Produces the IF/ID register (`instr_IFID`, `pc_IFID`, `pcplus4_IFID`, `valid_IFID`) read by decode and by the hazard unit's `src1_ID`/`src2_ID` extraction.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC ownership, imem request handshake and IF/ID register.
// Optional FETCH_PERF_CNT_EN enables the stall/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_IFID,
  output logic [31:0] pc_IFID,
  output logic [31:0] pcplus4_IFID,
  output logic        valid_IFID,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pending_pc;
  logic              req_q;
  logic [XLEN-1:0]   redirect_tgt;

  // Redirect targets are word aligned.
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // The request and address come straight from registers, so no input reaches them combinationally.
  assign imem_req  = req_q;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pending_pc   <= '0;
      req_q        <= 1'b0;
      instr_IFID   <= NOP_INSTR;
      pc_IFID      <= '0;
      pcplus4_IFID <= '0;
      valid_IFID   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= FETCH;
          req_q      <= 1'b1;
          instr_IFID <= NOP_INSTR;
          valid_IFID <= 1'b0;
        end
        FETCH: begin
          if (!hold) begin
            if (redirect) begin
              // Wrong-path slot is squashed; an in-flight miss must drain first.
              instr_IFID <= NOP_INSTR;
              valid_IFID <= 1'b0;
              if (imem_ready) begin
                pc <= redirect_tgt;
              end else begin
                pending_pc <= redirect_tgt;
                state      <= DRAIN;
              end
            end else if (imem_ready) begin
              instr_IFID   <= imem_rdata;
              pc_IFID      <= pc;
              pcplus4_IFID <= pc + XLEN'(4);
              valid_IFID   <= 1'b1;
              pc           <= pc + XLEN'(4);
            end else begin
              instr_IFID <= NOP_INSTR;
              valid_IFID <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (redirect) begin
            pending_pc <= redirect_tgt;
          end
          // Returned data belongs to the abandoned path and is dropped; newest target wins.
          if (imem_ready) begin
            pc    <= redirect ? redirect_tgt : pending_pc;
            state <= FETCH;
          end
          if (!hold) begin
            instr_IFID <= NOP_INSTR;
            valid_IFID <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = (state != BOOT) && (hold || (!imem_ready && imem_req));
  assign flush_evt = redirect && (((state == FETCH) && !hold) || (state == DRAIN));

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + XLEN'(1);
      end
      if (flush_evt && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + XLEN'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle model pushes expected IF/ID and fetch outputs per step.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int M_BOOT  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_IFID;
  logic [31:0] pc_IFID;
  logic [31:0] pcplus4_IFID;
  logic        valid_IFID;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] addr;
    logic [31:0] stall;
    logic [31:0] flush;
    logic        valid;
    logic        req;
  } exp_t;

  exp_t sb[$];

  int          m_state;
  logic [31:0] m_pc, m_pend, m_instr, m_pcif, m_p4, m_stall, m_flush;
  logic        m_valid;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_IFID  (instr_IFID),
    .pc_IFID     (pc_IFID),
    .pcplus4_IFID(pcplus4_IFID),
    .valid_IFID  (valid_IFID),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = 32'h0;
    m_pend  = 32'h0;
    m_instr = NOP;
    m_pcif  = 32'h0;
    m_p4    = 32'h0;
    m_valid = 1'b0;
    m_stall = 32'h0;
    m_flush = 32'h0;
  endtask

  task automatic model_step(input logic h, input logic r, input logic [31:0] rp, input logic rdy);
    logic [31:0] tgt;
    logic        bub;
    tgt = rp & 32'hFFFF_FFFC;
    bub = 1'b0;
    if (m_state != M_BOOT && (h || !rdy) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    case (m_state)
      M_BOOT: begin
        m_state = M_FETCH;
        bub = 1'b1;
      end
      M_FETCH: begin
        if (h) begin
          bub = 1'b0;
        end else if (r) begin
          bub = 1'b1;
          if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
          if (rdy) m_pc = tgt;
          else begin
            m_pend  = tgt;
            m_state = M_DRAIN;
          end
        end else if (rdy) begin
          m_instr = mem_word(m_pc);
          m_pcif  = m_pc;
          m_p4    = m_pc + 4;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
        end else begin
          bub = 1'b1;
        end
      end
      default: begin
        if (r) begin
          m_pend = tgt;
          if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end
        if (rdy) begin
          m_pc    = m_pend;
          m_state = M_FETCH;
        end
        bub = !h;
      end
    endcase
    if (bub) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic h, input logic r, input logic [31:0] rp, input logic rdy);
    exp_t e;
    hold        = h;
    redirect    = r;
    redirect_pc = rp;
    imem_ready  = rdy;
    model_step(h, r, rp, rdy);
    e.instr = m_instr;
    e.pc    = m_pcif;
    e.p4    = m_p4;
    e.addr  = m_pc;
    e.valid = m_valid;
    e.req   = (m_state != M_BOOT);
`ifdef FETCH_PERF_CNT_EN
    e.stall = m_stall;
    e.flush = m_flush;
`else
    e.stall = 32'h0;
    e.flush = 32'h0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("instr_IFID", instr_IFID, e.instr);
    check_eq("valid_IFID", 32'(valid_IFID), 32'(e.valid));
    check_eq("pc_IFID", pc_IFID, e.pc);
    check_eq("pcplus4_IFID", pcplus4_IFID, e.p4);
    check_eq("imem_addr", imem_addr, e.addr);
    check_eq("imem_req", 32'(imem_req), 32'(e.req));
    check_eq("stall_cnt", stall_cnt, e.stall);
    check_eq("flush_cnt", flush_cnt, e.flush);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req), 32'h0);
    check_eq({tag, "_addr"}, imem_addr, 32'h0);
    check_eq({tag, "_instr"}, instr_IFID, NOP);
    check_eq({tag, "_valid"}, 32'(valid_IFID), 32'h0);
    check_eq({tag, "_pc"}, pc_IFID, 32'h0);
    check_eq({tag, "_p4"}, pcplus4_IFID, 32'h0);
    check_eq({tag, "_stall"}, stall_cnt, 32'h0);
    check_eq({tag, "_flush"}, flush_cnt, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] flush_snap;
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    hold        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b1;
    model_reset();
    #2;
    check_reset_outputs("reset");
    #6;
    rst_n = 1'b1;

    // Boot cycle, then straight-line fetch of 0,4,8,C.
    cycle(1'b0, 1'b1, 32'h0000_0800, 1'b1);
    check_eq("boot_valid", 32'(valid_IFID), 32'h0);
    check_eq("boot_addr", imem_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("seq_0", instr_IFID, mem_word(32'h0));
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("seq_4", instr_IFID, mem_word(32'h4));
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("seq_8", instr_IFID, mem_word(32'h8));
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Hold for three cycles at PC 0x10, one of them with a coincident redirect.
    flush_snap = flush_cnt;
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0700, 1'b1);
    check_eq("hold_redir_addr", imem_addr, 32'h10);
    check_eq("hold_redir_flush", flush_cnt, flush_snap);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("hold_instr", instr_IFID, mem_word(32'hC));
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("post_hold_instr", instr_IFID, mem_word(32'h10));

    // Advance to PC 0x20 and redirect with zero wait.
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("at_20", imem_addr, 32'h20);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    check_eq("redir_bubble", 32'(valid_IFID), 32'h0);
    check_eq("redir_addr", imem_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_instr", instr_IFID, mem_word(32'h100));

    // Redirect during a memory wait at 0x40, newer redirect while draining.
    cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    check_eq("drain_addr0", imem_addr, 32'h40);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    check_eq("drain_addr1", imem_addr, 32'h40);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("drain_done_addr", imem_addr, 32'h300);
    check_eq("drain_no_valid", 32'(valid_IFID), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("drain_next_instr", instr_IFID, mem_word(32'h300));

    // Wrap from 0xFFFF_FFFC; low target bits are dropped.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_next", imem_addr, 32'h0);
    check_eq("wrap_p4", pcplus4_IFID, 32'h0);

    // Randomised mix of hold, memory wait and redirects.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Reset asserted asynchronously while draining.
    cycle(1'b0, 1'b1, 32'h0000_0500, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("drain_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
